// File: rtl/bram_mul_sequencer_pkg.sv
// Shared definitions for the BRAM-staged multiplier sequencer.
//   - state_t        : sequencer state encoding
//   - A_LSB          : bit position of operand A inside a packed BRAM word
//   - b_lsb()        : bit position of operand B (upper half of the BRAM word)
//   - ring_ptr_width : width of the ring pointer / res_idx for a ring depth
//   - LAT_CNT_W      : width of the latency down-counter (latencies up to 4)
package bram_mul_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_OP    = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_MUL_WAIT = 3'd3,
        ST_WR_RES   = 3'd4
    } state_t;

    localparam int A_LSB     = 0;
    localparam int LAT_CNT_W = 3;

    // Operand B lives in the upper half of the BRAM word.
    function automatic int b_lsb(input int bram_width);
        return bram_width / 2;
    endfunction

    // A depth-1 ring still needs a one-bit pointer to keep port widths legal.
    function automatic int ring_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bram_mul_sequencer_lat_counter.sv
// Loadable down-counter with a done flag; times the BRAM read wait and the
// DSP wait of the sequencer.
//   clk, rst    : clock, asynchronous active-high reset
//   i_load      : load i_load_val (takes priority over i_dec)
//   i_load_val  : value to load; the wait lasts i_load_val+1 cycles
//   i_dec       : decrement by one
//   o_done      : counter is at zero
module bram_mul_sequencer_lat_counter
    import bram_mul_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [LAT_CNT_W-1:0] i_load_val,
    input  logic                 i_dec,
    output logic                 o_done
);

    logic [LAT_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec) begin
            r_cnt <= r_cnt - LAT_CNT_W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/bram_mul_sequencer.sv
// BRAM-staged multiplier sequencer. Accepts an operand pair over valid/ready,
// packs it into one BRAM word on port A, reads it back after RD_LAT cycles,
// drives the external DSP, waits DSP_LAT cycles and writes the product into
// the result ring on port B. Both rings share one pointer.
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid/in_ready        : operand handshake; dataA, dataB operands
//   out_valid, dataC         : one-cycle product pulse and product
//   res_idx, wrap            : ring slot written, pulse when pointer wraps
//   wrA/addrA/dinA, doutA    : BRAM port A (operand write and readback)
//   wrB/addrB/dinB           : BRAM port B (result write)
//   A, B, C                  : DSP operands and product
module bram_mul_sequencer
    import bram_mul_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int MUL_WIDTH  = 25,
    parameter int BRAM_WIDTH = 18,
    parameter int BRAM_ADDR  = 12,
    parameter int OP_BASE    = 0,
    parameter int RES_BASE   = 64,
    parameter int RING_DEPTH = 64,
    parameter int RD_LAT     = 1,
    parameter int DSP_LAT    = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DATA_WIDTH-1:0]                  dataA,
    input  logic [DATA_WIDTH-1:0]                  dataB,
    output logic                                   out_valid,
    output logic [2*DATA_WIDTH-1:0]                dataC,
    output logic [ring_ptr_width(RING_DEPTH)-1:0]  res_idx,
    output logic                                   wrap,
    output logic                                   wrA,
    output logic [BRAM_ADDR-1:0]                   addrA,
    output logic [BRAM_WIDTH-1:0]                  dinA,
    input  logic [BRAM_WIDTH-1:0]                  doutA,
    output logic                                   wrB,
    output logic [BRAM_ADDR-1:0]                   addrB,
    output logic [BRAM_WIDTH-1:0]                  dinB,
    output logic [MUL_WIDTH-1:0]                   A,
    output logic [BRAM_WIDTH-1:0]                  B,
    input  logic [MUL_WIDTH+BRAM_WIDTH-1:0]        C
);

    localparam int PTR_W = ring_ptr_width(RING_DEPTH);
    localparam int B_LSB = b_lsb(BRAM_WIDTH);
    localparam int PW    = 2 * DATA_WIDTH;

    state_t               r_state;
    logic [PTR_W-1:0]     r_ptr;
    logic [BRAM_WIDTH-1:0] w_pack;
    logic                 w_cnt_load;
    logic [LAT_CNT_W-1:0] w_cnt_val;
    logic                 w_cnt_dec;
    logic                 w_cnt_done;
    logic                 w_unused;

    // Only the operand fields of doutA and the low product bits of C matter.
    assign w_unused = ^{doutA, C};

    always_comb begin
        w_pack = '0;
        w_pack[A_LSB +: DATA_WIDTH] = dataA;
        w_pack[B_LSB +: DATA_WIDTH] = dataB;
    end

    // WR_OP arms the read wait (RD_LAT cycles); the read-wait exit arms the
    // DSP wait, which spans DSP_LAT+1 cycles so the registered A/B have
    // DSP_LAT full cycles to propagate before WR_RES samples C.
    always_comb begin
        w_cnt_load = 1'b0;
        w_cnt_val  = '0;
        w_cnt_dec  = 1'b0;
        case (r_state)
            ST_WR_OP: begin
                w_cnt_load = 1'b1;
                w_cnt_val  = LAT_CNT_W'(RD_LAT - 1);
            end
            ST_RD_WAIT: begin
                if (w_cnt_done) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = LAT_CNT_W'(DSP_LAT);
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_MUL_WAIT: w_cnt_dec = !w_cnt_done;
            default: ;
        endcase
    end

    bram_mul_sequencer_lat_counter u_lat_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_done     (w_cnt_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            dataC     <= '0;
            res_idx   <= '0;
            wrap      <= 1'b0;
            wrA       <= 1'b0;
            addrA     <= '0;
            dinA      <= '0;
            wrB       <= 1'b0;
            addrB     <= '0;
            dinB      <= '0;
            A         <= '0;
            B         <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    wrB       <= 1'b0;
                    out_valid <= 1'b0;
                    wrap      <= 1'b0;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        wrA      <= 1'b1;
                        addrA    <= BRAM_ADDR'(OP_BASE) + BRAM_ADDR'(r_ptr);
                        dinA     <= w_pack;
                        r_state  <= ST_WR_OP;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ST_WR_OP: begin
                    // addrA stays put so the same word is read back.
                    wrA     <= 1'b0;
                    r_state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (w_cnt_done) begin
                        A       <= MUL_WIDTH'(doutA[A_LSB +: DATA_WIDTH]);
                        B       <= BRAM_WIDTH'(doutA[B_LSB +: DATA_WIDTH]);
                        r_state <= ST_MUL_WAIT;
                    end
                end
                ST_MUL_WAIT: begin
                    if (w_cnt_done) begin
                        r_state <= ST_WR_RES;
                    end
                end
                ST_WR_RES: begin
                    wrB       <= 1'b1;
                    addrB     <= BRAM_ADDR'(RES_BASE) + BRAM_ADDR'(r_ptr);
                    dinB      <= BRAM_WIDTH'(C[PW-1:0]);
                    dataC     <= C[PW-1:0];
                    res_idx   <= r_ptr;
                    out_valid <= 1'b1;
                    wrap      <= (r_ptr == PTR_W'(RING_DEPTH - 1));
                    r_ptr     <= r_ptr + PTR_W'(1);
                    in_ready  <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_mul_sequencer.sv
module tb_bram_mul_sequencer;

    localparam int DW       = 4;
    localparam int MW       = 25;
    localparam int BW       = 18;
    localparam int AW       = 12;
    localparam int OP_BASE  = 0;
    localparam int RES_BASE = 64;
    localparam int DEPTH    = 64;
    parameter  int RD_LAT   = 1;
    parameter  int DSP_LAT  = 1;
    localparam int LAT      = 3 + RD_LAT + DSP_LAT;
    localparam int DSP_IDX  = (DSP_LAT == 0) ? 0 : DSP_LAT - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   dataA;
    logic [DW-1:0]   dataB;
    logic            out_valid;
    logic [2*DW-1:0] dataC;
    logic [5:0]      res_idx;
    logic            wrap;
    logic            wrA;
    logic [AW-1:0]   addrA;
    logic [BW-1:0]   dinA;
    logic [BW-1:0]   doutA;
    logic            wrB;
    logic [AW-1:0]   addrB;
    logic [BW-1:0]   dinB;
    logic [MW-1:0]   A;
    logic [BW-1:0]   B;
    logic [MW+BW-1:0] C;

    int checks   = 0;
    int failures = 0;
    int exp_ptr  = 0;
    int wra_cnt  = 0;
    int wrb_cnt  = 0;
    int ov_cnt   = 0;
    int wrap_cnt = 0;
    int ovl_cnt  = 0;

    always #5 clk = ~clk;

    bram_mul_sequencer #(
        .DATA_WIDTH (DW),
        .MUL_WIDTH  (MW),
        .BRAM_WIDTH (BW),
        .BRAM_ADDR  (AW),
        .OP_BASE    (OP_BASE),
        .RES_BASE   (RES_BASE),
        .RING_DEPTH (DEPTH),
        .RD_LAT     (RD_LAT),
        .DSP_LAT    (DSP_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dataA     (dataA),
        .dataB     (dataB),
        .out_valid (out_valid),
        .dataC     (dataC),
        .res_idx   (res_idx),
        .wrap      (wrap),
        .wrA       (wrA),
        .addrA     (addrA),
        .dinA      (dinA),
        .doutA     (doutA),
        .wrB       (wrB),
        .addrB     (addrB),
        .dinB      (dinB),
        .A         (A),
        .B         (B),
        .C         (C)
    );

    // Dual-port BRAM with RD_LAT-cycle read on port A.
    logic [BW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] a_q [0:3];
    always @(posedge clk) begin
        if (wrA) mem[addrA] <= dinA;
        if (wrB) mem[addrB] <= dinB;
        a_q[0] <= addrA;
        for (int i = 1; i < 4; i++) a_q[i] <= a_q[i-1];
    end
    assign doutA = mem[a_q[RD_LAT-1]];

    // DSP multiplier with DSP_LAT pipeline stages.
    logic [MW+BW-1:0] prod_c;
    logic [MW+BW-1:0] p_q [0:4];
    assign prod_c = (MW+BW)'(A) * (MW+BW)'(B);
    always @(posedge clk) begin
        p_q[0] <= prod_c;
        for (int i = 1; i < 5; i++) p_q[i] <= p_q[i-1];
    end
    assign C = (DSP_LAT == 0) ? prod_c : p_q[DSP_IDX];

    // Event counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (wrA === 1'b1) wra_cnt++;
        if (wrB === 1'b1) wrb_cnt++;
        if (out_valid === 1'b1) ov_cnt++;
        if (wrap === 1'b1) wrap_cnt++;
        if (wrA === 1'b1 && wrB === 1'b1) ovl_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rst_checks();
        chk("rst_ctrl", 64'({in_ready, out_valid, wrap, wrA, wrB}), 64'd0);
        chk("rst_addr", 64'({addrA, addrB}), 64'd0);
        chk("rst_din",  64'({dinA, dinB}), 64'd0);
        chk("rst_dsp",  64'({A, B}), 64'd0);
        chk("rst_out",  64'({dataC, res_idx}), 64'd0);
    endtask

    task automatic send(input int a, input int b, input bit hold, output bit ok);
        bit rdy;
        ok = 1'b0;
        dataA = DW'(a);
        dataB = DW'(b);
        in_valid = 1'b1;
        for (int n = 0; n < 60; n++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!hold) in_valid = 1'b0;
        chk("accept", 64'(ok), 64'd1);
        if (ok) begin
            chk("wrA_set",    64'(wrA), 64'd1);
            chk("addrA",      64'(addrA), 64'(OP_BASE + exp_ptr));
            chk("dinA",       64'(dinA), 64'((b << (BW/2)) | a));
            chk("busy_ready", 64'(in_ready), 64'd0);
            chk("idle_clear", 64'({wrB, out_valid, wrap}), 64'd0);
        end
    endtask

    task automatic complete(input int a, input int b, input bit noise);
        int k;
        int low;
        bit seen;
        k = 0;
        low = 0;
        seen = 1'b0;
        while (k < 60 && !seen) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                dataA = DW'($urandom);
                dataB = DW'($urandom);
            end
            if (in_ready == 1'b0) low++;
            @(posedge clk); #1;
            k++;
            seen = out_valid;
        end
        if (noise) in_valid = 1'b0;
        chk("result_seen", 64'(seen), 64'd1);
        chk("latency",     64'(k), 64'(LAT));
        chk("ready_low",   64'(low), 64'(LAT));
        chk("dataC",       64'(dataC), 64'((a * b) % (1 << (2*DW))));
        chk("res_idx",     64'(res_idx), 64'(exp_ptr));
        chk("wrap",        64'(wrap), 64'(exp_ptr == DEPTH - 1));
        chk("wrB_set",     64'(wrB), 64'd1);
        chk("addrB",       64'(addrB), 64'(RES_BASE + exp_ptr));
        chk("dinB",        64'(dinB), 64'(a * b));
        chk("dsp_A",       64'(A), 64'(a));
        chk("dsp_B",       64'(B), 64'(b));
        chk("ready_back",  64'(in_ready), 64'd1);
        exp_ptr = (exp_ptr + 1) % DEPTH;
    endtask

    task automatic do_pair(input int a, input int b, input bit hold, input bit noise);
        bit ok;
        send(a, b, hold, ok);
        if (ok) complete(a, b, noise);
    endtask

    initial begin
        bit ok;
        int wa0;
        int wb0;
        int ov0;
        int wp0;

        rst = 1'b1;
        in_valid = 1'b0;
        dataA = '0;
        dataB = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_checks();
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", 64'(in_ready), 64'd1);

        // Directed first pair, then back-to-back pairs with in_valid held.
        do_pair(15, 15, 1'b0, 1'b0);
        do_pair(3, 4, 1'b1, 1'b0);
        do_pair(0, 9, 1'b1, 1'b0);
        do_pair(7, 2, 1'b0, 1'b0);
        @(posedge clk); #1;

        // in_valid toggling while busy must not start extra transactions.
        wa0 = wra_cnt;
        wb0 = wrb_cnt;
        ov0 = ov_cnt;
        for (int i = 0; i < 4; i++)
            do_pair(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("noise_wrA_count", 64'(wra_cnt - wa0), 64'd4);
        chk("noise_wrB_count", 64'(wrb_cnt - wb0), 64'd4);
        chk("noise_ov_count",  64'(ov_cnt - ov0), 64'd4);

        // Random pairs across a full ring wrap.
        wp0 = wrap_cnt;
        for (int i = 0; i < 70; i++)
            do_pair(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("wrap_count", 64'(wrap_cnt - wp0), 64'd1);

        // Reset in the middle of MUL_WAIT abandons the transaction.
        send(9, 9, 1'b0, ok);
        repeat (RD_LAT + 1) @(posedge clk);
        #1;
        wb0 = wrb_cnt;
        ov0 = ov_cnt;
        rst = 1'b1;
        #1;
        rst_checks();
        @(posedge clk); #1;
        rst_checks();
        rst = 1'b0;
        exp_ptr = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_no_wrB", 64'(wrb_cnt - wb0), 64'd0);
        chk("midrst_no_ov",  64'(ov_cnt - ov0), 64'd0);
        chk("midrst_ready",  64'(in_ready), 64'd1);
        do_pair(2, 2, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("mem_result",  64'(mem[RES_BASE]), 64'd4);
        chk("mem_operand", 64'(mem[OP_BASE]), 64'((2 << (BW/2)) | 2));
        chk("no_overlap",  64'(ovl_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
